// File: rtl/uart_pkg.sv
// Shared UART definitions: conf field layout, length/stop decode and FSM states.
// Also used by the receiver, so nothing here is transmitter-specific.
package uart_pkg;

  // Bit offsets of the fields inside the 5-bit configuration word.
  localparam int unsigned ConfParityBit = 0;
  localparam int unsigned ConfStopLsb   = 1;
  localparam int unsigned ConfDataLsb   = 3;

  // Data-length field values.
  localparam logic [1:0] DataLen5 = 2'b00;
  localparam logic [1:0] DataLen6 = 2'b01;
  localparam logic [1:0] DataLen7 = 2'b10;
  localparam logic [1:0] DataLen8 = 2'b11;

  // Stop field: only 00 means a single stop bit, all other codes mean two.
  localparam logic [1:0] StopOne = 2'b00;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

  // Index of the last data bit: 5 bits -> 4, ..., 8 bits -> 7.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] len);
    return {1'b1, len};
  endfunction

  function automatic logic is_two_stop(input logic [1:0] stop);
    return stop != StopOne;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..div-1 and strobes bit_end_o on the last count.
// The divisor is captured on load_i so the caller may change div_i freely.
module uart_bit_timer #(
  parameter int unsigned DIV_W = 14
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             en_i,
  output logic             bit_end_o
);

  localparam logic [DIV_W-1:0] One = DIV_W'(1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;

  // Strobe in the last clock of each bit period.
  always_comb begin
    bit_end_o = en_i && (cnt_q == (div_q - One));
  end

  // Divisor shadow and period counter; cleared whenever the timer is idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      div_q <= div_i;
      cnt_q <= '0;
    end else if (!en_i || bit_end_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + One;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 5-8 data bits LSB first, optional even parity,
// 1 or 2 stop bits. All frame settings are shadowed when start_i is accepted.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned MAX_UART_DATA_W = 8,
  parameter int unsigned STOP_CONF_W     = 2,
  parameter int unsigned DATA_CONF_W     = 2,
  parameter int unsigned BAUD_RATE_SEL_W = 2,
  parameter int unsigned TOTAL_CONF_W    = STOP_CONF_W + DATA_CONF_W + 1,
  parameter int unsigned BAUD_DIV_0      = 10417,
  parameter int unsigned BAUD_DIV_1      = 5208,
  parameter int unsigned BAUD_DIV_2      = 1736,
  parameter int unsigned BAUD_DIV_3      = 868,
  parameter int unsigned DIV_W           = 14
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic                       start_i,
  input  logic [TOTAL_CONF_W-1:0]    conf_i,
  input  logic [MAX_UART_DATA_W-1:0] data_i,
  input  logic [BAUD_RATE_SEL_W-1:0] baud_sel_i,
  output logic                       tx_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int unsigned IdxW = 3;

  uart_state_e state_q, state_d;

  logic [MAX_UART_DATA_W-1:0] data_q, data_d;
  logic [DATA_CONF_W-1:0]     len_q, len_d;
  logic                       two_stop_q, two_stop_d;
  logic                       parity_en_q, parity_en_d;
  logic                       parity_q, parity_d;
  logic [IdxW-1:0]            bit_idx_q, bit_idx_d;
  logic                       stop_idx_q, stop_idx_d;
  logic                       tx_q, tx_d;
  logic                       done_q, done_d;

  logic                       accept;
  logic                       timer_load;
  logic                       timer_en;
  logic                       bit_end;
  logic [DIV_W-1:0]           sel_div;
  logic [DATA_CONF_W-1:0]     conf_len;
  logic                       cap_parity;
  logic [IdxW-1:0]            nxt_idx;

  assign conf_len = conf_i[ConfDataLsb +: DATA_CONF_W];
  assign accept   = start_i && en_i && (state_q == StIdle);
  assign timer_en = en_i && (state_q != StIdle);
  assign nxt_idx  = bit_idx_q + IdxW'(1);

  // Divisor chosen by baud_sel_i; only sampled on acceptance.
  always_comb begin
    sel_div = DIV_W'(BAUD_DIV_0);
    case (baud_sel_i)
      BAUD_RATE_SEL_W'(1): sel_div = DIV_W'(BAUD_DIV_1);
      BAUD_RATE_SEL_W'(2): sel_div = DIV_W'(BAUD_DIV_2);
      BAUD_RATE_SEL_W'(3): sel_div = DIV_W'(BAUD_DIV_3);
      default:             sel_div = DIV_W'(BAUD_DIV_0);
    endcase
  end

  // Even parity over the bits that will actually be sent, computed at capture.
  always_comb begin
    cap_parity = 1'b0;
    for (int i = 0; i < MAX_UART_DATA_W; i++) begin
      if (IdxW'(i) <= last_bit_idx(conf_len)) begin
        cap_parity = cap_parity ^ data_i[i];
      end
    end
  end

  uart_bit_timer #(
    .DIV_W (DIV_W)
  ) u_bit_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (timer_load),
    .div_i     (sel_div),
    .en_i      (timer_en),
    .bit_end_o (bit_end)
  );

  // Frame sequencing; tx_d is the line level for the cycle after the edge.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    len_d       = len_q;
    two_stop_d  = two_stop_q;
    parity_en_d = parity_en_q;
    parity_d    = parity_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    tx_d        = tx_q;
    done_d      = 1'b0;
    timer_load  = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (accept) begin
          timer_load  = 1'b1;
          data_d      = data_i;
          len_d       = conf_len;
          two_stop_d  = is_two_stop(conf_i[ConfStopLsb +: STOP_CONF_W]);
          parity_en_d = conf_i[ConfParityBit];
          parity_d    = cap_parity;
          bit_idx_d   = '0;
          stop_idx_d  = 1'b0;
          tx_d        = 1'b0;
          state_d     = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          tx_d    = data_q[0];
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_idx_q == last_bit_idx(len_q)) begin
            if (parity_en_q) begin
              tx_d    = parity_q;
              state_d = StParity;
            end else begin
              tx_d    = 1'b1;
              state_d = StStop;
            end
          end else begin
            bit_idx_d = nxt_idx;
            tx_d      = data_q[nxt_idx];
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (two_stop_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase

    // Disabling mid-frame drops the frame silently.
    if (!en_i && (state_q != StIdle)) begin
      state_d = StIdle;
      tx_d    = 1'b1;
      done_d  = 1'b0;
    end
  end

  // State, shadow and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      data_q      <= '0;
      len_q       <= '0;
      two_stop_q  <= 1'b0;
      parity_en_q <= 1'b0;
      parity_q    <= 1'b0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      len_q       <= len_d;
      two_stop_q  <= two_stop_d;
      parity_en_q <= parity_en_d;
      parity_q    <= parity_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = (state_q != StIdle);
  assign done_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus pushes the expected line waveform,
// a negedge monitor captures each frame and compares it on done_o.
module tb_uart_tx;

  localparam int Limit = 200;

  logic       clk;
  logic       rst;
  logic       en;
  logic       start;
  logic [4:0] conf;
  logic [7:0] data;
  logic [1:0] baud_sel;
  logic       tx;
  logic       busy;
  logic       done;

  typedef struct {
    int           start_cyc;
    int           len;
    logic [127:0] wave;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;
  int   cyc;
  int   divs[4];

  uart_tx #(
    .BAUD_DIV_0 (4),
    .BAUD_DIV_1 (3),
    .BAUD_DIV_2 (5),
    .BAUD_DIV_3 (2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .start_i    (start),
    .conf_i     (conf),
    .data_i     (data),
    .baud_sel_i (baud_sel),
    .tx_o       (tx),
    .busy_o     (busy),
    .done_o     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame: list the line bits from the frame rules, then stretch
  // each one over div clocks.
  function automatic void build_frame(input logic [7:0] d, input logic [4:0] c, input int div,
                                      output logic [127:0] w, output int len);
    bit bits[$];
    int nd;
    int ns;
    int ones;
    nd = 5 + int'(c[4:3]);
    ns = (c[2:1] == 2'b00) ? 1 : 2;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < nd; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (c[0]) bits.push_back(bit'(ones % 2));
    for (int i = 0; i < ns; i++) bits.push_back(1'b1);
    w = '0;
    len = 0;
    foreach (bits[b]) begin
      for (int k = 0; k < div; k++) begin
        w[len] = bits[b];
        len++;
      end
    end
  endfunction

  // Issue a start in the current cycle; returns one cycle later.
  task automatic send(input logic [7:0] d, input logic [4:0] c, input logic [1:0] b,
                      input bit expect_done);
    exp_t e;
    data     = d;
    conf     = c;
    baud_sel = b;
    start    = 1'b1;
    if (expect_done) begin
      e.start_cyc = cyc;
      build_frame(d, c, divs[b], e.wave, e.len);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Advance until done_o is seen; optionally scramble inputs and pulse start
  // while the frame is in flight.
  task automatic wait_done(input bit wiggle);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      start = 1'b0;
      if (wiggle && busy) begin
        data     = 8'($urandom);
        conf     = 5'($urandom);
        baud_sel = 2'($urandom);
        start    = 1'($urandom_range(0, 1));
      end
    end while (!done && n < Limit);
    start = 1'b0;
    if (!done) check("done_timeout", 0, 1);
  endtask

  // Monitor: capture tx while busy, compare against the scoreboard on done.
  bit           in_frame;
  bit           prev_done;
  int           rise_cyc;
  int           cap_len;
  logic [127:0] cap_wave;

  always @(negedge clk) begin
    exp_t e;
    if (done && prev_done) check("done_width", 2, 1);
    if (busy && !in_frame) begin
      in_frame = 1'b1;
      rise_cyc = cyc;
      cap_len  = 0;
      cap_wave = '0;
    end
    if (busy) begin
      if (cap_len < 128) cap_wave[cap_len] = tx;
      cap_len++;
    end
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("busy_rise_cycle", 128'(rise_cyc), 128'(e.start_cyc + 1));
        check("done_cycle", 128'(cyc), 128'(e.start_cyc + 1 + e.len));
        check("frame_len", 128'(cap_len), 128'(e.len));
        check("frame_wave", cap_wave, e.wave);
        check("done_busy_low", 128'(busy), 0);
        check("done_tx_idle", 128'(tx), 1);
      end
      in_frame = 1'b0;
    end else if (!busy) begin
      in_frame = 1'b0;
    end
    prev_done = done;
  end

  initial begin
    int n;
    divs[0] = 4;
    divs[1] = 3;
    divs[2] = 5;
    divs[3] = 2;
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    rst = 1'b1;
    en = 1'b1;
    start = 1'b0;
    conf = '0;
    data = '0;
    baud_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", 128'(tx), 1);
    check("reset_busy", 128'(busy), 0);
    check("reset_done", 128'(done), 0);
    rst = 1'b0;
    while (cyc < 10) begin
      @(posedge clk);
      #1;
    end

    // 8N1 A5, start in cycle 10.
    send(8'hA5, 5'b11_00_0, 2'd0, 1'b1);
    wait_done(1'b0);
    repeat (3) @(posedge clk);
    #1;

    // 5 data bits, 2 stop, parity.
    send(8'h07, 5'b00_01_1, 2'd0, 1'b1);
    wait_done(1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back: second start in the done cycle, mid-frame start pulses.
    send(8'h5A, 5'b11_00_1, 2'd0, 1'b1);
    wait_done(1'b1);
    send(8'h3C, 5'b11_00_0, 2'd0, 1'b1);
    wait_done(1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Enable dropped during data bit 3.
    send(8'hFF, 5'b11_00_0, 2'd0, 1'b0);
    repeat (17) @(posedge clk);
    #1;
    check("pre_abort_busy", 128'(busy), 1);
    en = 1'b0;
    @(posedge clk);
    #1;
    check("abort_tx", 128'(tx), 1);
    check("abort_busy", 128'(busy), 0);
    check("abort_done", 128'(done), 0);
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(8'h96, 5'b11_00_1, 2'd0, 1'b1);
    wait_done(1'b0);

    // Fast divisor with inputs toggling mid-frame.
    send(8'hC3, 5'b10_01_1, 2'd3, 1'b1);
    wait_done(1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Reset inside the stop bit.
    send(8'h1F, 5'b00_00_0, 2'd0, 1'b0);
    repeat (25) @(posedge clk);
    #1;
    check("pre_reset_tx", 128'(tx), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_tx", 128'(tx), 1);
    check("rst_busy", 128'(busy), 0);
    check("rst_done", 128'(done), 0);
    repeat (10) @(posedge clk);
    #1;

    // Randomized frames, some back-to-back, plus ignored starts with en low.
    for (int f = 0; f < 24; f++) begin
      send(8'($urandom), 5'($urandom), 2'($urandom), 1'b1);
      wait_done(f[0]);
      if (f % 3 == 1) begin
        repeat (2) @(posedge clk);
        #1;
        en = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        en = 1'b1;
        check("en_low_idle", 128'(busy), 0);
      end else if (f % 3 == 2) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    n = 0;
    while (sb.size() != 0 && n < Limit) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", 128'(sb.size()), 0);
    check("final_idle", 128'(busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial transmitter that consumes the Tx control outputs of the UART register controller: enable, start strobe, 5-bit configuration, data byte and baud select. It produces the serial line `tx_o` and returns the `busy`/`done` status that feeds the controller's `tx_busy_i`/`tx_done_i`. Frame format is start bit, 5–8 data bits LSB first, optional even parity, then 1 or 2 stop bits.

Parameters:
- MAX_UART_DATA_W, 8, width of the data input.
- STOP_CONF_W, 2, width of the stop-bit config field.
- DATA_CONF_W, 2, width of the data-length config field.
- BAUD_RATE_SEL_W, 2, width of the baud select input.
- TOTAL_CONF_W, STOP_CONF_W+DATA_CONF_W+1, width of the config input.
- BAUD_DIV_0, 10417, clocks per bit for baud_sel=0 (9600 Bd at 100 MHz).
- BAUD_DIV_1, 5208, clocks per bit for baud_sel=1.
- BAUD_DIV_2, 1736, clocks per bit for baud_sel=2.
- BAUD_DIV_3, 868, clocks per bit for baud_sel=3.
- DIV_W, 14, width of the bit-period counter (must hold the maximum BAUD_DIV).

Ports:
- clk_i  in  1  top clock
- rst_i  in  1  synchronous active-high reset
- en_i  in  1  transmitter enable
- start_i  in  1  one-cycle request to send data_i
- conf_i  in  TOTAL_CONF_W  {data[1:0], stop[1:0], parity_en}
- data_i  in  MAX_UART_DATA_W  byte to transmit
- baud_sel_i  in  BAUD_RATE_SEL_W  selects a BAUD_DIV_n value
- tx_o  out  1  serial line, idle high
- busy_o  out  1  high while a frame is in progress
- done_o  out  1  one-cycle pulse when a frame completes

Behaviour:
- Single clock `clk_i`; reset `rst_i` is synchronous and active-high.
- Reset values: tx_o=1, busy_o=0, done_o=0, FSM=IDLE, all counters and shadow registers 0.
- Config decode:
  - data field: 00=5, 01=6, 10=7, 11=8 bits.
  - stop field: 00=1 stop bit, 01/10/11=2 stop bits.
  - parity_en=1 inserts an even-parity bit (XOR of the transmitted data bits only).
- Acceptance: start_i is accepted only when en_i=1 and FSM=IDLE.
  - On acceptance in cycle N, data_i, conf_i and the divisor selected by baud_sel_i are captured into shadow registers.
  - Input changes after capture have no effect on the frame in flight.
  - start_i while busy is ignored (no queuing).
  - start_i with en_i=0 is ignored.
- FSM: IDLE -> START -> DATA -> [PARITY if parity_en] -> STOP -> IDLE.
- Each bit lasts exactly DIV clocks. A bit counter counts 0..DIV-1; the state or bit index advances when the counter reaches DIV-1.
- Output timing:
  - tx_o is registered: it goes to 0 in cycle N+1.
  - busy_o is 1 from N+1.
- Frame length F = (1 + D + P + S) × DIV cycles, where D = data bits, P = parity bit count (0/1), S = stop bits.
- Completion:
  - tx_o holds 1 through the stop period(s).
  - In cycle N+1+F: busy_o=0 and done_o=1 for exactly that cycle.
  - A start_i in that same cycle is accepted, giving back-to-back frames with no idle gap.
- Unused upper data bits (D<8) are never shifted out.
- en_i deasserted mid-frame: abort at the next clock edge. FSM=IDLE, tx_o=1, busy_o=0, and no done_o pulse.
- rst_i mid-frame: immediate return to reset values at the next edge.
- A baud_sel_i change mid-frame has no effect (the divisor is shadowed).

Decomposition:
- Shared header `uart_defines.vh` holds:
  - conf field bit offsets (PARITY_EN bit 0, STOP [2:1], DATA [4:3]);
  - data-length and stop-count decode constants;
  - FSM state encodings (IDLE, START, DATA, PARITY, STOP), shared with the future uart_rx.
- One natural sub-module: `uart_bit_timer`. It takes a divisor load plus enable and outputs a bit-end strobe. It is reused by uart_rx, with a half-period option added later.

Test Plan:
- BAUD_DIV_0=4, conf=5'b11_00_0, data=8'hA5, start in cycle 10:
  - tx_o=0 cycles 11–14;
  - then bits 1,0,1,0,0,1,0,1 at 4 cycles each;
  - stop=1 for 4 cycles;
  - done_o=1 only in cycle 51; busy_o 1 for cycles 11–50.
- conf=5'b00_01_1 (5 data bits, 2 stop, parity), data=8'h07, DIV=4:
  - 5 data bits 1,1,1,0,0, then parity=1, then 8 cycles of stop;
  - F=36 cycles.
- Second start_i in the done_o cycle, data=8'h3C:
  - tx_o goes low the next cycle, with zero idle gap;
  - start_i pulses mid-frame produce no extra frame.
- en_i dropped during DATA bit 3:
  - the next cycle shows tx_o=1, busy_o=0, and no done_o;
  - a subsequent start with en_i=1 yields a complete correct frame.
- baud_sel_i=3 with BAUD_DIV_3=2, toggling baud_sel_i and data_i mid-frame:
  - every bit is 2 cycles and the captured data is sent unchanged.
- rst_i asserted mid-STOP: next cycle tx_o=1, busy_o=0, done_o=0, and no done pulse afterwards.
